// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO between the core and data memory.
// Stores are queued as {address, data} pairs and drained head-first to the
// memory port; nothing is coalesced or reordered. Pushing while full drops
// the store and sets a sticky overflow flag.
// Optional feature: define STORE_BUF_FWD_EN to build the load-forwarding
// comparators. Without it, fwd_hit and fwd_data are tied to zero.
module store_buffer #(
  parameter int DEPTH = 4  // power of two, 2..16
) (
  input  logic                     clk,
  input  logic                     reset,      // asynchronous, active low
  input  logic                     MemWrite,
  input  logic [31:0]              DataAdr,
  input  logic [31:0]              WriteData,
  input  logic                     ReadEn,
  input  logic [31:0]              ReadAdr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     mem_valid,
  output logic [31:0]              mem_adr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_adr  [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;

  // Status flags come straight from the count register, so they never
  // depend on this cycle's inputs.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A store arriving while full is dropped even if the head pops this cycle.
  assign w_push = MemWrite & ~w_full;
  assign w_pop  = ~w_empty & mem_ready;

  // Pointers, occupancy and the sticky overflow flag.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (MemWrite && w_full) r_overflow <= 1'b1;
    end
  end

  // Entry storage written at the tail on every accepted push.
  // NOTE: the entry array has no reset; a slot is only read once the count
  // says it holds a valid store, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_adr[r_tail]  <= DataAdr;
      r_data[r_tail] <= WriteData;
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign mem_valid = ~w_empty;
  // Head is driven only from registered storage: a new push is visible the
  // cycle after it lands, and the head holds while memory stalls.
  assign mem_adr   = w_empty ? '0 : r_adr[r_head];
  assign mem_wdata = w_empty ? '0 : r_data[r_head];

`ifdef STORE_BUF_FWD_EN
  // Scan from oldest to youngest so the youngest matching store wins. The
  // popping head is still counted as valid; a same-cycle push is not yet.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    logic [PW-1:0] w_idx;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (ReadEn && (CW'(i) < r_count) && (r_adr[w_idx] == ReadAdr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_idx];
      end
    end
  end
`else
  // Forwarding disabled: ports stay, outputs are constant, probe is ignored.
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = '0;
  wire w_unused_fwd = &{1'b0, ReadEn, ReadAdr};
`endif

  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_data;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven and randomized checks of store_buffer
// against a queue-based reference model of the store FIFO.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [31:0]   DataAdr;
  logic [31:0]   WriteData;
  logic          ReadEn;
  logic [31:0]   ReadAdr;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          mem_valid;
  logic [31:0]   mem_adr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic          fwd_hit;
  logic [31:0]   fwd_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadEn    (ReadEn),
    .ReadAdr   (ReadAdr),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .mem_valid (mem_valid),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

  // Reference model: a queue of pending stores, oldest at index 0.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] data;
    logic        rdy;
    int          e_count;
    logic        e_valid;
    logic [31:0] e_adr;
    logic [31:0] e_data;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every output against what the model says for the current inputs.
  task automatic check_model(input string tag);
    int          n;
    logic [31:0] e_adr;
    logic [31:0] e_data;
    logic        e_hit;
    logic [31:0] e_fd;
    n      = q.size();
    e_adr  = '0;
    e_data = '0;
    e_hit  = 1'b0;
    e_fd   = '0;
    if (n > 0) begin
      e_adr  = q[0].adr;
      e_data = q[0].data;
    end
    if (ReadEn) begin
      for (int i = 0; i < n; i++) begin
        if (q[i].adr == ReadAdr) begin
          e_hit = 1'b1;
          e_fd  = q[i].data;
        end
      end
    end
    if (!FWD) begin
      e_hit = 1'b0;
      e_fd  = '0;
    end
    check({tag, ".count"},     32'(count),     32'(n));
    check({tag, ".full"},      32'(full),      32'(n == DEPTH));
    check({tag, ".empty"},     32'(empty),     32'(n == 0));
    check({tag, ".mem_valid"}, 32'(mem_valid), 32'(n != 0));
    check({tag, ".mem_adr"},   mem_adr,        e_adr);
    check({tag, ".mem_wdata"}, mem_wdata,      e_data);
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".fwd_hit"},   32'(fwd_hit),   32'(e_hit));
    check({tag, ".fwd_data"},  fwd_data,       e_fd);
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    int n;
    n = q.size();
    if (MemWrite && n == DEPTH) m_ovf = 1'b1;
    if (n > 0 && mem_ready) void'(q.pop_front());
    if (MemWrite && n < DEPTH) q.push_back('{adr: DataAdr, data: WriteData});
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then clock.
  task automatic apply(input logic mw, input logic [31:0] adr, input logic [31:0] data,
                       input logic rdy, input logic ren, input logic [31:0] radr,
                       input string tag);
    MemWrite  = mw;
    DataAdr   = adr;
    WriteData = data;
    mem_ready = rdy;
    ReadEn    = ren;
    ReadAdr   = radr;
    #2;
    check_model(tag);
    clock_edge();
  endtask

  task automatic do_reset(input string tag);
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    mem_ready = 1'b0;
    ReadEn    = 1'b0;
    ReadAdr   = '0;
    reset     = 1'b0;
    q.delete();
    m_ovf     = 1'b0;
    #2;
    check_model(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic add_vec(input logic mw, input logic [31:0] adr, input logic [31:0] data,
                         input logic rdy, input int e_count, input logic e_valid,
                         input logic [31:0] e_adr, input logic [31:0] e_data,
                         input logic e_full, input logic e_ovf);
    vecs.push_back('{mw: mw, adr: adr, data: data, rdy: rdy, e_count: e_count,
                     e_valid: e_valid, e_adr: e_adr, e_data: e_data,
                     e_full: e_full, e_ovf: e_ovf});
  endtask

  initial begin
    int next_pop;
    int next_push;

    // Table: inputs for one cycle, then the expected state after that edge.
    //       mw  adr  data rdy cnt val adr  data full ovf
    add_vec(1,  100, 25,  0,  1,  1,  100, 25,  0,   0);  // first push, stalled
    add_vec(0,  0,   0,   0,  1,  1,  100, 25,  0,   0);  // stall 1
    add_vec(0,  0,   0,   0,  1,  1,  100, 25,  0,   0);  // stall 2
    add_vec(0,  0,   0,   0,  1,  1,  100, 25,  0,   0);  // stall 3
    add_vec(0,  0,   0,   1,  0,  0,  0,   0,   0,   0);  // drain
    add_vec(1,  96,  7,   0,  1,  1,  96,  7,   0,   0);
    add_vec(1,  100, 25,  0,  2,  1,  96,  7,   0,   0);
    add_vec(1,  104, 3,   0,  3,  1,  96,  7,   0,   0);
    add_vec(1,  108, 9,   0,  4,  1,  96,  7,   1,   0);  // now full
    add_vec(1,  112, 1,   0,  4,  1,  96,  7,   1,   1);  // dropped, overflow
    add_vec(0,  0,   0,   1,  3,  1,  100, 25,  0,   1);
    add_vec(0,  0,   0,   1,  2,  1,  104, 3,   0,   1);
    add_vec(0,  0,   0,   1,  1,  1,  108, 9,   0,   1);
    add_vec(0,  0,   0,   1,  0,  0,  0,   0,   0,   1);  // empty, flag sticks
    add_vec(1,  1,   11,  0,  1,  1,  1,   11,  0,   1);
    add_vec(1,  2,   12,  0,  2,  1,  1,   11,  0,   1);
    add_vec(1,  3,   13,  0,  3,  1,  1,   11,  0,   1);
    add_vec(1,  4,   14,  0,  4,  1,  1,   11,  1,   1);
    add_vec(1,  5,   15,  1,  3,  1,  2,   12,  0,   1);  // push+pop at full
    add_vec(0,  0,   0,   1,  2,  1,  3,   13,  0,   1);
    add_vec(0,  0,   0,   1,  1,  1,  4,   14,  0,   1);
    add_vec(0,  0,   0,   1,  0,  0,  0,   0,   0,   1);  // store 5 never appears

    // Reset values with reset held from time zero.
    do_reset("reset0");
    check("reset0.fwd_hit_const", 32'(fwd_hit), 32'(0));

    // Table-driven scenarios.
    foreach (vecs[k]) begin
      apply(vecs[k].mw, vecs[k].adr, vecs[k].data, vecs[k].rdy, 1'b0, '0,
            $sformatf("tbl%0d", k));
      check($sformatf("tbl%0d.count_exp", k),    32'(count),     32'(vecs[k].e_count));
      check($sformatf("tbl%0d.valid_exp", k),    32'(mem_valid), 32'(vecs[k].e_valid));
      check($sformatf("tbl%0d.adr_exp", k),      mem_adr,        vecs[k].e_adr);
      check($sformatf("tbl%0d.data_exp", k),     mem_wdata,      vecs[k].e_data);
      check($sformatf("tbl%0d.full_exp", k),     32'(full),      32'(vecs[k].e_full));
      check($sformatf("tbl%0d.ovf_exp", k),      32'(overflow),  32'(vecs[k].e_ovf));
    end

    // Alternating push/pop around count=2 for 20 stores, across pointer wrap.
    do_reset("wrap_rst");
    next_push = 0;
    next_pop  = 0;
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 32'h200 + 32'(4 * next_push), 32'(3 * next_push + 1), 1'b0, 1'b0, '0, "wrap_fill");
      next_push++;
    end
    while (next_pop < 20) begin
      if (next_push < 20) begin
        apply(1'b1, 32'h200 + 32'(4 * next_push), 32'(3 * next_push + 1), 1'b0, 1'b0, '0, "wrap_push");
        next_push++;
      end
      MemWrite  = 1'b0;
      mem_ready = 1'b1;
      ReadEn    = 1'b0;
      #2;
      check($sformatf("wrap.adr%0d", next_pop),  mem_adr,   32'h200 + 32'(4 * next_pop));
      check($sformatf("wrap.data%0d", next_pop), mem_wdata, 32'(3 * next_pop + 1));
      check_model("wrap_pop");
      clock_edge();
      next_pop++;
    end
    check("wrap.empty_end", 32'(empty), 32'(1));

    // Forwarding: youngest match wins, popping head counts, pushing entry does not.
    do_reset("fwd_rst");
    apply(1'b1, 100, 25, 1'b0, 1'b0, '0, "fwd_p1");
    apply(1'b1, 100, 40, 1'b0, 1'b0, '0, "fwd_p2");
    MemWrite = 1'b0; mem_ready = 1'b0; ReadEn = 1'b1; ReadAdr = 100; #1;
    check("fwd.hit100",  32'(fwd_hit), 32'(FWD));
    check("fwd.data100", fwd_data,     FWD ? 32'd40 : 32'd0);
    ReadAdr = 104; #1;
    check("fwd.hit104",  32'(fwd_hit), 32'(0));
    check("fwd.data104", fwd_data,     32'(0));
    ReadEn = 1'b0; ReadAdr = 100; #1;
    check("fwd.noren",   32'(fwd_hit), 32'(0));
    clock_edge();
    apply(1'b0, 0, 0, 1'b1, 1'b0, '0, "fwd_pop1");  // leaves only 100/40
    MemWrite = 1'b1; DataAdr = 104; WriteData = 77;
    mem_ready = 1'b1; ReadEn = 1'b1; ReadAdr = 100; #1;
    check("fwd.pophead_hit",  32'(fwd_hit), 32'(FWD));
    check("fwd.pophead_data", fwd_data,     FWD ? 32'd40 : 32'd0);
    ReadAdr = 104; #1;
    check("fwd.pushing_hit",  32'(fwd_hit), 32'(0));
    check_model("fwd_swap");
    clock_edge();
    MemWrite = 1'b0; mem_ready = 1'b0; ReadEn = 1'b1; ReadAdr = 104; #1;
    check("fwd.pushed_hit",  32'(fwd_hit), 32'(FWD));
    check("fwd.pushed_data", fwd_data,     FWD ? 32'd77 : 32'd0);
    ReadAdr = 100; #1;
    check("fwd.popped_hit",  32'(fwd_hit), 32'(0));
    clock_edge();

    // Asynchronous reset in the middle of a drain.
    do_reset("mid_rst0");
    for (int k = 0; k < 4; k++)
      apply(1'b1, 32'h300 + 32'(4 * k), 32'(k + 50), 1'b0, 1'b0, '0, "mid_fill");
    apply(1'b0, 0, 0, 1'b1, 1'b0, '0, "mid_drain");
    check("mid.count3", 32'(count), 32'(3));
    #2;
    reset = 1'b0;
    #1;
    check("mid.valid_async", 32'(mem_valid), 32'(0));
    check("mid.count_async", 32'(count),     32'(0));
    check("mid.empty_async", 32'(empty),     32'(1));
    check("mid.adr_async",   mem_adr,        32'(0));
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("mid.valid_held", 32'(mem_valid), 32'(0));
    reset = 1'b1;
    #1;
    check_model("mid_release");
    @(posedge clk);
    model_edge();
    #1;

    // Randomized traffic on a small address set so forwarding hits occur.
    do_reset("rnd_rst");
    for (int k = 0; k < 400; k++) begin
      apply(1'($urandom_range(0, 99) < 55),
            32'(4 * $urandom_range(0, 5)),
            $urandom,
            1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 1)),
            32'(4 * $urandom_range(0, 5)),
            "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
